// File: rtl/div_unit_pkg.sv
// ============================================================================
//  Module  : div_unit_pkg
//  Purpose : Shared types and constants for the iterative divider.
//  Contents: div_state_t (FSM encoding), datapath widths, step count.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int DBL_W      = 64;
  localparam int DIV_CYCLES = 32;

  // Value of the step counter on the final quotient bit.
  localparam logic [4:0] DIV_LAST = 5'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage : div_unit_pkg

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
//  Module  : div_unit
//  Purpose : Iterative radix-2 restoring divider for DIV / DIVU.
//            One quotient bit per cycle; a zero divisor finishes immediately.
//  Ports   : clk        - clock
//            rst        - synchronous active-high reset
//            start      - request, held until ready is seen
//            signed_div - 1 = two's complement divide, 0 = unsigned
//            opr1       - dividend
//            opr2       - divisor
//            cancel     - pipeline flush / exception abort
//            res        - {remainder, quotient}
//            ready      - one-cycle result-valid pulse
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] opr1,
  input  logic [DATA_W-1:0] opr2,
  input  logic              cancel,
  output logic [DBL_W-1:0]  res,
  output logic              ready
);

  div_state_t        r_state;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_rem;      // partial remainder
  logic [DATA_W-1:0] r_dvd;      // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0] r_dvs;      // |divisor|
  logic              r_signed;
  logic              r_sdvd;     // dividend sign: remainder follows it
  logic              r_sdiff;    // operand signs differ: quotient is negated
  logic [DBL_W-1:0]  r_res;

  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_trial;
  logic              w_qbit;
  logic [DATA_W-1:0] w_rem_nx;
  logic [DATA_W-1:0] w_quo_nx;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

  always_comb begin
    w_abs1 = (signed_div && opr1[DATA_W-1]) ? (~opr1 + 1'b1) : opr1;
    w_abs2 = (signed_div && opr2[DATA_W-1]) ? (~opr2 + 1'b1) : opr2;

    // Shift {rem, dvd} left by one, then try to subtract the divisor.
    w_shift  = {r_rem, r_dvd[DATA_W-1]};
    w_trial  = w_shift - {1'b0, r_dvs};
    w_qbit   = ~w_trial[DATA_W];
    // A non-negative trial is always below the divisor, so 32 bits suffice.
    w_rem_nx = w_qbit ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
    w_quo_nx = {r_dvd[DATA_W-2:0], w_qbit};

    // 0x80000000 / -1 yields 0x80000000 naturally: its negation wraps to itself.
    w_quo_fix = (r_signed && r_sdiff) ? (~w_quo_nx + 1'b1) : w_quo_nx;
    w_rem_fix = (r_signed && r_sdvd)  ? (~w_rem_nx + 1'b1) : w_rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_signed <= 1'b0;
      r_sdvd   <= 1'b0;
      r_sdiff  <= 1'b0;
      r_res    <= '0;
    end else if (cancel) begin
      // Abort from any state; the last result is left untouched.
      r_state <= DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            if (opr2 == '0) begin
              r_res   <= '0;
              r_state <= DIV_DONE;
            end else begin
              r_dvd    <= w_abs1;
              r_dvs    <= w_abs2;
              r_signed <= signed_div;
              r_sdvd   <= opr1[DATA_W-1];
              r_sdiff  <= opr1[DATA_W-1] ^ opr2[DATA_W-1];
              r_rem    <= '0;
              r_cnt    <= '0;
              r_state  <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          r_rem <= w_rem_nx;
          r_dvd <= w_quo_nx;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == DIV_LAST) begin
            r_res   <= {w_rem_fix, w_quo_fix};
            r_state <= DIV_DONE;
          end
        end
        // Always return through IDLE so back-to-back ops see ready drop.
        DIV_DONE: r_state <= DIV_IDLE;
        default:  r_state <= DIV_IDLE;
      endcase
    end
  end

  assign res   = r_res;
  assign ready = (r_state == DIV_DONE) && !cancel;

endmodule : div_unit

`default_nettype wire
